// File: rtl/frame_packer_if.sv
// Pixel-stream handshake and frame-RAM write bus for frame_packer.
// The slave modport is the packer's view and the master modport is the source/sink side.
interface frame_packer_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              i_pix_valid;
    logic [7:0]        i_pix_data;
    logic              o_pix_ready;
    logic              o_wr;
    logic [ADDR_W-1:0] o_addr_write;
    logic [53:0]       o_data_line;

    modport master (
        output i_pix_valid,
        output i_pix_data,
        input  o_pix_ready,
        input  o_wr,
        input  o_addr_write,
        input  o_data_line
    );

    modport slave (
        input  i_pix_valid,
        input  i_pix_data,
        output o_pix_ready,
        output o_wr,
        output o_addr_write,
        output o_data_line
    );
endinterface

// File: rtl/frame_packer.sv
// frame_packer: packs RGB332 pixel bytes six at a time into 54-bit words
// and writes them to consecutive frame-RAM addresses, one frame per start pulse.
module frame_packer #(
    parameter int unsigned FRAME_WORDS = 3360,
    parameter int unsigned ADDR_W      = 12
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_frame_start,
    frame_packer_if.slave  bus,
    output logic           o_frame_done,
    output logic           o_short_frame,
    output logic           o_require_data
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        idx_q;
    logic [47:0]       pack_q;
    logic              pix_ready_q;
    logic              wr_q;
    logic [53:0]       data_q;
    logic              done_q;
    logic              short_q;
    logic              req_q;

    logic              accept_d;
    logic [53:0]       word_d;

    // Byte handshake and the completed word including the byte arriving now.
    always_comb begin
        accept_d = bus.i_pix_valid & pix_ready_q;
        word_d   = {6'd0, bus.i_pix_data, pack_q[39:0]};
    end

    // Frame FSM; every output is a register updated alongside the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            idx_q       <= '0;
            pack_q      <= '0;
            pix_ready_q <= 1'b0;
            wr_q        <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            req_q       <= 1'b1;
        end else begin
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_frame_start) begin
                        state_q     <= FILL;
                        addr_q      <= '0;
                        idx_q       <= '0;
                        pack_q      <= '0;
                        pix_ready_q <= 1'b1;
                        req_q       <= 1'b0;
                    end
                end
                FILL: begin
                    if (i_frame_start) begin
                        // Restart wins over a byte accepted on the same edge.
                        addr_q  <= '0;
                        idx_q   <= '0;
                        pack_q  <= '0;
                        short_q <= 1'b1;
                    end else if (accept_d) begin
                        if (idx_q == 3'd5) begin
                            // Word complete: index and pack register are cleared on
                            // entry to WRITE so FILL resumes with a clean slate.
                            state_q     <= WRITE;
                            pix_ready_q <= 1'b0;
                            wr_q        <= 1'b1;
                            data_q      <= word_d;
                            idx_q       <= '0;
                            pack_q      <= '0;
                        end else begin
                            pack_q[{idx_q, 3'b000} +: 8] <= bus.i_pix_data;
                            idx_q                        <= idx_q + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    state_q     <= FILL;
                    pix_ready_q <= 1'b1;
                    if (i_frame_start) begin
                        addr_q  <= '0;
                        short_q <= 1'b1;
                    end else if (addr_q == LAST_ADDR) begin
                        state_q     <= DONE;
                        pix_ready_q <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    addr_q  <= '0;
                    req_q   <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    pix_ready_q <= 1'b0;
                    req_q       <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_pix_ready  = pix_ready_q;
    assign bus.o_wr         = wr_q;
    assign bus.o_addr_write = addr_q;
    assign bus.o_data_line  = data_q;
    assign o_frame_done     = done_q;
    assign o_short_frame    = short_q;
    assign o_require_data   = req_q;

endmodule

// File: tb/tb_frame_packer.sv
// Directed testbench for frame_packer with a 4-word frame.
module tb_frame_packer;

    localparam int unsigned FW = 4;
    localparam int unsigned AW = 2;

    logic clk;
    logic rst_n;
    logic frame_start;
    logic frame_done;
    logic short_frame;
    logic require_data;

    frame_packer_if #(.ADDR_W(AW)) bus ();

    frame_packer #(.FRAME_WORDS(FW), .ADDR_W(AW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_frame_start  (frame_start),
        .bus            (bus.slave),
        .o_frame_done   (frame_done),
        .o_short_frame  (short_frame),
        .o_require_data (require_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int failed = 0;

    int cyc = 0;
    int done_cnt = 0;
    int short_cnt = 0;
    int acc_cnt = 0;
    int viol = 0;
    int done_cyc = 0;
    int last_wr_cyc = 0;
    int sc = 0;
    logic [53:0]   wq_data[$];
    logic [AW-1:0] wq_addr[$];

    always @(posedge clk) cyc++;

    // Observe the DUT mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.o_wr === 1'b1) begin
            wq_addr.push_back(bus.o_addr_write);
            wq_data.push_back(bus.o_data_line);
            last_wr_cyc = cyc;
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (short_frame === 1'b1) short_cnt++;
        if (bus.i_pix_valid === 1'b1 && bus.o_pix_ready === 1'b1) acc_cnt++;
        if (bus.o_wr === 1'b1 && bus.o_pix_ready === 1'b1) viol++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        bus.i_pix_valid = 1'b1;
        bus.i_pix_data  = b;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (bus.o_pix_ready === 1'b1) got = 1'b1;
        end
        if (got) begin
            @(posedge clk);
            #1;
        end
        bus.i_pix_valid = 1'b0;
        if (!got) check("send_timeout", 64'(got), 64'd1);
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        sc = cyc;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int n = 0; n < 100 && done_cnt < target; n++) begin
            @(posedge clk);
            #2;
        end
        check("done_count", 64'(done_cnt), 64'(target));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [53:0] word_of(input int base);
        logic [53:0] e;
        e = '0;
        for (int j = 0; j < 6; j++) e[8*j +: 8] = 8'(base + j);
        return e;
    endfunction

    initial begin
        rst_n           = 1'b0;
        frame_start     = 1'b0;
        bus.i_pix_valid = 1'b1;
        bus.i_pix_data  = 8'hAB;

        // Reset values with valid already high.
        repeat (3) @(negedge clk);
        check("rst_require", 64'(require_data), 64'd1);
        check("rst_ready", 64'(bus.o_pix_ready), 64'd0);
        check("rst_wr", 64'(bus.o_wr), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_short", 64'(short_frame), 64'd0);
        check("rst_addr", 64'(bus.o_addr_write), 64'd0);
        check("rst_data", 64'(bus.o_data_line), 64'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(6);
        check("nostart_acc", 64'(acc_cnt), 64'd0);
        check("nostart_wr", 64'(wq_data.size()), 64'd0);
        check("nostart_require", 64'(require_data), 64'd1);
        bus.i_pix_valid = 1'b0;
        idle_cycles(1);

        // Full frame, continuous valid.
        pulse_start();
        for (int i = 0; i < 24; i++) send_byte(8'(i));
        wait_done(1);
        check("ff_nwr", 64'(wq_data.size()), 64'd4);
        for (int w = 0; w < 4; w++) begin
            if (w < wq_data.size()) begin
                check("ff_addr", 64'(wq_addr[w]), 64'(w));
                check("ff_data", 64'(wq_data[w]), 64'(word_of(6 * w)));
            end
        end
        check("ff_latency", 64'(done_cyc - sc + 1), 64'(7 * FW + 2));
        check("ff_done_after_wr", 64'(done_cyc - last_wr_cyc), 64'd1);
        check("ff_require", 64'(require_data), 64'd1);
        check("ff_short", 64'(short_cnt), 64'd0);
        idle_cycles(3);
        check("ff_done_once", 64'(done_cnt), 64'd1);

        // Same frame with random valid gaps.
        wq_data.delete();
        wq_addr.delete();
        pulse_start();
        for (int i = 0; i < 24; i++) begin
            idle_cycles(int'($urandom_range(0, 2)));
            send_byte(8'(i));
        end
        wait_done(2);
        check("gap_nwr", 64'(wq_data.size()), 64'd4);
        for (int w = 0; w < 4; w++) begin
            if (w < wq_data.size()) begin
                check("gap_addr", 64'(wq_addr[w]), 64'(w));
                check("gap_data", 64'(wq_data[w]), 64'(word_of(6 * w)));
            end
        end
        check("gap_ready_during_wr", 64'(viol), 64'd0);

        // Single word then abort after 3 stale bytes.
        wq_data.delete();
        wq_addr.delete();
        idle_cycles(2);
        pulse_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
        send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
        pulse_start();
        idle_cycles(2);
        check("abort_short", 64'(short_cnt), 64'd1);
        check("abort_nwr", 64'(wq_data.size()), 64'd1);
        if (wq_data.size() > 0) begin
            check("word0_addr", 64'(wq_addr[0]), 64'd0);
            check("word0_data", 64'(wq_data[0]), 64'h00_6655_4433_2211);
        end
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        send_byte(8'hA4); send_byte(8'hA5); send_byte(8'hA6);
        idle_cycles(2);
        check("restart_nwr", 64'(wq_data.size()), 64'd2);
        if (wq_data.size() > 1) begin
            check("restart_addr", 64'(wq_addr[1]), 64'd0);
            check("restart_data", 64'(wq_data[1]), 64'h00_A6A5_A4A3_A2A1);
        end

        // Asynchronous reset in the middle of a word.
        send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(bus.o_pix_ready), 64'd0);
        check("arst_require", 64'(require_data), 64'd1);
        check("arst_addr", 64'(bus.o_addr_write), 64'd0);
        check("arst_wr", 64'(bus.o_wr), 64'd0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(2);
        check("arst_nwr", 64'(wq_data.size()), 64'd2);
        pulse_start();
        send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3);
        send_byte(8'hB4); send_byte(8'hB5); send_byte(8'hB6);
        idle_cycles(2);
        check("post_arst_nwr", 64'(wq_data.size()), 64'd3);
        if (wq_data.size() > 2) begin
            check("post_arst_addr", 64'(wq_addr[2]), 64'd0);
            check("post_arst_data", 64'(wq_data[2]), 64'h00_B6B5_B4B3_B2B1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
